// File: rtl/text_buffer_if.sv
// Character-stream and raster read bus for the text buffer.
// The source side (master) pushes ASCII codes and raster positions; the
// buffer side (slave) returns the cell contents and cursor state.
interface text_buffer_if;
  logic [6:0] char_in;
  logic       char_valid;
  logic       char_ready;
  logic [9:0] xPixel;
  logic [9:0] yPixel;
  logic [6:0] char_code;
  logic       cursor_hit;
  logic [5:0] cursor_col;
  logic [3:0] cursor_row;

  modport master (
    output char_in,
    output char_valid,
    output xPixel,
    output yPixel,
    input  char_ready,
    input  char_code,
    input  cursor_hit,
    input  cursor_col,
    input  cursor_row
  );

  modport slave (
    input  char_in,
    input  char_valid,
    input  xPixel,
    input  yPixel,
    output char_ready,
    output char_code,
    output cursor_hit,
    output cursor_col,
    output cursor_row
  );
endinterface

// File: rtl/text_buffer.sv
// 40x15 character-cell frame buffer with a typewriter cursor.
// Accepts ASCII over valid/ready, handles LF/CR/BS/FF, clears rows as the
// cursor advances onto them, and returns the cell under the raster position
// one cycle later for the downstream font stage.
module text_buffer (
  input  logic          VGA_clk,
  input  logic          reset_n,
  text_buffer_if.slave  bus
);

  localparam int         COLS      = 40;
  localparam int         ROWS      = 15;
  localparam logic [5:0] LAST_COL  = 6'(COLS - 1);
  localparam logic [3:0] LAST_ROW  = 4'(ROWS - 1);
  localparam logic [9:0] LAST_ADDR = 10'(COLS * ROWS - 1);
  localparam logic [9:0] X_LIMIT   = 10'd640;
  localparam logic [9:0] Y_LIMIT   = 10'd480;
  localparam logic [6:0] BLANK     = 7'h20;
  localparam logic [6:0] CODE_BS   = 7'h08;
  localparam logic [6:0] CODE_LF   = 7'h0A;
  localparam logic [6:0] CODE_FF   = 7'h0C;
  localparam logic [6:0] CODE_CR   = 7'h0D;

  typedef enum logic [1:0] {
    CLEAR_ALL = 2'd0,
    CLEAR_ROW = 2'd1,
    IDLE      = 2'd2
  } state_t;

  // Linear cell address row*COLS+col; both operands are small, so 10 bits hold it.
  function automatic logic [9:0] cell_addr(input logic [3:0] row, input logic [5:0] col);
    cell_addr = ({6'd0, row} * 10'(COLS)) + {4'd0, col};
  endfunction

  // Row advance wraps explicitly from the last row back to the top.
  function automatic logic [3:0] next_row(input logic [3:0] row);
    next_row = (row == LAST_ROW) ? 4'd0 : row + 4'd1;
  endfunction

  // Character storage: single write port, single read port, not reset.
  logic [6:0] mem [0:COLS*ROWS-1];

  state_t     state_r, state_s;
  logic [9:0] clr_cnt_r, clr_cnt_s;
  logic [5:0] col_r, col_s;
  logic [3:0] row_r, row_s;
  logic       char_ready_r;
  logic       ready_s;
  logic       accept_s;
  logic       printable_s;

  logic       we_s;
  logic [9:0] waddr_s;
  logic [6:0] wdata_s;

  logic       in_range_s;
  logic [5:0] rd_col_s;
  logic [3:0] rd_row_s;
  logic [9:0] raddr_s;
  logic [6:0] char_code_r;
  logic       cursor_hit_r;

  assign accept_s    = bus.char_valid && char_ready_r;
  assign printable_s = (bus.char_in >= 7'h20) && (bus.char_in <= 7'h7E);

  // FSM, clear counter, cursor and ready flag registers.
  always_ff @(posedge VGA_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= CLEAR_ALL;
      clr_cnt_r    <= 10'd0;
      col_r        <= 6'd0;
      row_r        <= 4'd0;
      char_ready_r <= 1'b0;
    end else begin
      state_r      <= state_s;
      clr_cnt_r    <= clr_cnt_s;
      col_r        <= col_s;
      row_r        <= row_s;
      char_ready_r <= ready_s;
    end
  end

  // Next-state, cursor update and write-port selection.
  always_comb begin
    state_s   = state_r;
    clr_cnt_s = clr_cnt_r;
    col_s     = col_r;
    row_s     = row_r;
    we_s      = 1'b0;
    waddr_s   = 10'd0;
    wdata_s   = BLANK;

    case (state_r)
      CLEAR_ALL: begin
        we_s    = 1'b1;
        waddr_s = clr_cnt_r;
        if (clr_cnt_r == LAST_ADDR) begin
          state_s   = IDLE;
          clr_cnt_s = 10'd0;
        end else begin
          clr_cnt_s = clr_cnt_r + 10'd1;
        end
      end

      CLEAR_ROW: begin
        // The cursor row already points at the row being blanked.
        we_s    = 1'b1;
        waddr_s = cell_addr(row_r, clr_cnt_r[5:0]);
        if (clr_cnt_r[5:0] == LAST_COL) begin
          state_s   = IDLE;
          clr_cnt_s = 10'd0;
        end else begin
          clr_cnt_s = clr_cnt_r + 10'd1;
        end
      end

      IDLE: begin
        if (accept_s) begin
          case (bus.char_in)
            CODE_LF: begin
              col_s     = 6'd0;
              row_s     = next_row(row_r);
              state_s   = CLEAR_ROW;
              clr_cnt_s = 10'd0;
            end
            CODE_CR: begin
              col_s = 6'd0;
            end
            CODE_BS: begin
              if (col_r != 6'd0) begin
                col_s   = col_r - 6'd1;
                we_s    = 1'b1;
                waddr_s = cell_addr(row_r, col_r - 6'd1);
                wdata_s = BLANK;
              end else begin
                col_s = col_r;
              end
            end
            CODE_FF: begin
              col_s     = 6'd0;
              row_s     = 4'd0;
              state_s   = CLEAR_ALL;
              clr_cnt_s = 10'd0;
            end
            default: begin
              if (printable_s) begin
                we_s    = 1'b1;
                waddr_s = cell_addr(row_r, col_r);
                wdata_s = bus.char_in;
                if (col_r == LAST_COL) begin
                  col_s     = 6'd0;
                  row_s     = next_row(row_r);
                  state_s   = CLEAR_ROW;
                  clr_cnt_s = 10'd0;
                end else begin
                  col_s = col_r + 6'd1;
                end
              end else begin
                // Unsupported control code: consumed without effect.
                col_s = col_r;
              end
            end
          endcase
        end else begin
          state_s = IDLE;
        end
      end

      default: begin
        state_s   = CLEAR_ALL;
        clr_cnt_s = 10'd0;
      end
    endcase

    ready_s = (state_s == IDLE);
  end

  // Storage write port; a same-cycle read of this address still sees old data.
  always_ff @(posedge VGA_clk) begin
    if (we_s) begin
      mem[waddr_s] <= wdata_s;
    end
  end

  // Raster position to cell address; off-screen positions never touch the array.
  always_comb begin
    rd_col_s   = bus.xPixel[9:4];
    rd_row_s   = bus.yPixel[8:5];
    in_range_s = (bus.xPixel < X_LIMIT) && (bus.yPixel < Y_LIMIT);
    if (in_range_s) begin
      raddr_s = cell_addr(rd_row_s, rd_col_s);
    end else begin
      raddr_s = 10'd0;
    end
  end

  // Registered read data and cursor-hit flag for the font stage.
  always_ff @(posedge VGA_clk or negedge reset_n) begin
    if (!reset_n) begin
      char_code_r  <= BLANK;
      cursor_hit_r <= 1'b0;
    end else if (in_range_s) begin
      char_code_r  <= mem[raddr_s];
      cursor_hit_r <= (rd_col_s == col_r) && (rd_row_s == row_r);
    end else begin
      char_code_r  <= BLANK;
      cursor_hit_r <= 1'b0;
    end
  end

  assign bus.char_ready = char_ready_r;
  assign bus.char_code  = char_code_r;
  assign bus.cursor_hit = cursor_hit_r;
  assign bus.cursor_col = col_r;
  assign bus.cursor_row = row_r;

endmodule

// File: tb/tb_text_buffer.sv
// Directed bench for text_buffer: reset/clear timing, typing, wraps,
// control codes and off-screen reads, all against hand-computed values.
module tb_text_buffer;

  logic clk;
  logic reset_n;
  int   n_checks;
  int   n_errors;

  text_buffer_if bus ();

  text_buffer dut (
    .VGA_clk (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  // 25 MHz-style free-running clock.
  initial begin
    clk = 1'b0;
    forever #20 clk = ~clk;
  end

  // Hard stop in case a wait escapes its bound.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input int actual, input int expected);
    n_checks++;
    if (actual != expected) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic read_pix(input int x, input int y, output int code, output int hit);
    bus.xPixel = 10'(x);
    bus.yPixel = 10'(y);
    tick();
    code = int'(bus.char_code);
    hit  = int'(bus.cursor_hit);
  endtask

  task automatic read_cell(input int col, input int row, output int code, output int hit);
    read_pix(col * 16 + 5, row * 32 + 17, code, hit);
  endtask

  // Present a character and hold it until the accepting edge has passed.
  task automatic send_char(input logic [6:0] c);
    int waited;
    waited = 0;
    bus.char_in    = c;
    bus.char_valid = 1'b1;
    while (!bus.char_ready && waited < 1000) begin
      tick();
      waited++;
    end
    if (waited >= 1000) begin
      check("send_ready", int'(bus.char_ready), 1);
    end
    tick();
    bus.char_valid = 1'b0;
    bus.char_in    = 7'h00;
  endtask

  // Cycles until char_ready rises, bounded.
  task automatic count_busy(output int cnt);
    cnt = 0;
    while (!bus.char_ready && cnt < 2000) begin
      tick();
      cnt++;
    end
  endtask

  // Count cells that do not read as blank across the whole grid.
  task automatic count_non_blank(output int bad);
    int code;
    int hit;
    bad = 0;
    for (int r = 0; r < 15; r++) begin
      for (int c = 0; c < 40; c++) begin
        read_cell(c, r, code, hit);
        if (code != 32'h20) bad++;
      end
    end
  endtask

  // Main directed sequence.
  initial begin
    int cnt;
    int code;
    int hit;
    int bad;

    n_checks       = 0;
    n_errors       = 0;
    reset_n        = 1'b0;
    bus.char_in    = 7'h00;
    bus.char_valid = 1'b0;
    bus.xPixel     = 10'd0;
    bus.yPixel     = 10'd0;

    tick();
    tick();
    check("rst_ready", int'(bus.char_ready), 0);
    check("rst_code", int'(bus.char_code), 32'h20);
    check("rst_hit", int'(bus.cursor_hit), 0);
    check("rst_col", int'(bus.cursor_col), 0);
    check("rst_row", int'(bus.cursor_row), 0);

    reset_n = 1'b1;
    count_busy(cnt);
    check("init_busy", cnt, 600);
    count_non_blank(bad);
    check("init_blank", bad, 0);
    read_pix(0, 0, code, hit);
    check("init_hit00", hit, 1);
    read_pix(16, 0, code, hit);
    check("init_hit10", hit, 0);

    // 'A' then 'B'
    send_char(7'h41);
    check("a_ready", int'(bus.char_ready), 1);
    send_char(7'h42);
    read_pix(0, 0, code, hit);
    check("a_cell", code, 32'h41);
    read_pix(16, 0, code, hit);
    check("b_cell", code, 32'h42);
    check("ab_col", int'(bus.cursor_col), 2);
    check("ab_row", int'(bus.cursor_row), 0);

    // 41 x 'Z' from column 0
    send_char(7'h0D);
    check("cr_col", int'(bus.cursor_col), 0);
    for (int i = 0; i < 39; i++) send_char(7'h5A);
    send_char(7'h5A);
    check("wrap_ready", int'(bus.char_ready), 0);
    check("wrap_col", int'(bus.cursor_col), 0);
    check("wrap_row", int'(bus.cursor_row), 1);
    count_busy(cnt);
    check("wrap_busy", cnt, 40);
    send_char(7'h5A);
    read_cell(39, 0, code, hit);
    check("z_39_0", code, 32'h5A);
    read_cell(0, 1, code, hit);
    check("z_0_1", code, 32'h5A);
    read_cell(1, 1, code, hit);
    check("z_1_1", code, 32'h20);
    check("z_1_1_hit", hit, 1);
    check("z_col", int'(bus.cursor_col), 1);
    check("z_row", int'(bus.cursor_row), 1);

    // Form feed over a populated screen
    send_char(7'h0C);
    check("ff_col", int'(bus.cursor_col), 0);
    check("ff_row", int'(bus.cursor_row), 0);
    count_busy(cnt);
    check("ff_busy", cnt, 600);
    count_non_blank(bad);
    check("ff_blank", bad, 0);

    // 'X' then 15 line feeds wraps back to row 0 and blanks it
    send_char(7'h58);
    for (int i = 0; i < 14; i++) send_char(7'h0A);
    check("lf14_row", int'(bus.cursor_row), 14);
    read_cell(0, 0, code, hit);
    check("x_cell", code, 32'h58);
    send_char(7'h0A);
    check("lf15_col", int'(bus.cursor_col), 0);
    check("lf15_row", int'(bus.cursor_row), 0);
    count_busy(cnt);
    check("lf15_busy", cnt, 40);
    read_cell(0, 0, code, hit);
    check("lf15_cell", code, 32'h20);

    // 'Q' then backspace twice
    send_char(7'h51);
    read_cell(0, 0, code, hit);
    check("q_cell", code, 32'h51);
    send_char(7'h08);
    read_cell(0, 0, code, hit);
    check("bs_cell", code, 32'h20);
    check("bs_col", int'(bus.cursor_col), 0);
    send_char(7'h08);
    check("bs2_col", int'(bus.cursor_col), 0);
    check("bs2_row", int'(bus.cursor_row), 0);
    check("bs2_ready", int'(bus.char_ready), 1);

    // Ignored code and carriage return keep contents
    send_char(7'h4D);
    send_char(7'h01);
    check("ign_col", int'(bus.cursor_col), 1);
    check("ign_ready", int'(bus.char_ready), 1);
    send_char(7'h0D);
    check("cr2_col", int'(bus.cursor_col), 0);
    read_cell(0, 0, code, hit);
    check("m_cell", code, 32'h4D);

    // Off-screen reads while (0,1) holds a visible character
    send_char(7'h0A);
    send_char(7'h57);
    read_cell(0, 1, code, hit);
    check("w_cell", code, 32'h57);
    check("w_hit", hit, 0);
    read_pix(640, 0, code, hit);
    check("x640_code", code, 32'h20);
    check("x640_hit", hit, 0);
    read_pix(700, 100, code, hit);
    check("x700_code", code, 32'h20);
    check("x700_hit", hit, 0);
    read_pix(0, 480, code, hit);
    check("y480_code", code, 32'h20);

    // Reset in the middle of a clear restarts a full clear
    send_char(7'h0C);
    for (int i = 0; i < 100; i++) tick();
    reset_n = 1'b0;
    tick();
    check("mid_rst_ready", int'(bus.char_ready), 0);
    reset_n = 1'b1;
    count_busy(cnt);
    check("mid_rst_busy", cnt, 600);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
